// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback commit stage.
package wb_commit_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned NUM_REGS         = 1 << REG_ADDR_W;
  localparam int unsigned LL_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Long-latency result FIFO: one push, up to two pops, head/head+1 peek.
// With WB_PENDING_EN it also exports a per-register mask of queued dests.
module wb_ll_fifo
  import wb_commit_pkg::*;
#(
  parameter int unsigned DEPTH = LL_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic [1:0]        pop,
  output wb_entry_t         head,
  output wb_entry_t         head_nxt,
`ifdef WB_PENDING_EN
  output logic [NUM_REGS-1:0] pending,
`endif
  output logic [CNT_W-1:0]  count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

`ifdef WB_PENDING_EN
  logic [PTR_W-1:0] ofs;

  // An entry is queued when its distance from the read pointer is below count.
  always_comb begin
    pending = '0;
    ofs     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ofs = PTR_W'(i) - rd_ptr;
      if (CNT_W'(ofs) < count) pending[mem[i].dest] = 1'b1;
    end
    pending[0] = 1'b0;
  end
`endif

endmodule

// File: rtl/wb_commit.sv
// Dual-issue writeback commit: merges two pipeline slots with queued
// long-latency results onto two registered register-file write ports.
// Optional feature macro: WB_PENDING_EN (exports LL_Pending mask).
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int unsigned LL_DEPTH = LL_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WB_Valid_1,
  input  logic [REG_ADDR_W-1:0] WB_Dest_1,
  input  logic [DATA_W-1:0]     WB_Data_1,
  input  logic                  WB_Valid_2,
  input  logic [REG_ADDR_W-1:0] WB_Dest_2,
  input  logic [DATA_W-1:0]     WB_Data_2,
  input  logic                  LL_Valid,
  output logic                  LL_Ready,
  input  logic [REG_ADDR_W-1:0] LL_Dest,
  input  logic [DATA_W-1:0]     LL_Data,
  output logic                  Write_Enable_1,
  output logic [REG_ADDR_W-1:0] Write_Addr_1,
  output logic [DATA_W-1:0]     Write_Data_1,
  output logic                  Write_Enable_2,
  output logic [REG_ADDR_W-1:0] Write_Addr_2,
`ifdef WB_PENDING_EN
  output logic [NUM_REGS-1:0]   LL_Pending,
`endif
  output logic [DATA_W-1:0]     Write_Data_2
);

  localparam int unsigned PTR_W = $clog2(LL_DEPTH);
  localparam int unsigned CNT_W = $clog2(LL_DEPTH) + 1;

  logic [CNT_W-1:0]      ll_count;
  wb_entry_t             head;
  wb_entry_t             head_nxt;
  wb_entry_t             push_entry;
  wb_entry_t             p2_entry;
  logic                  push;
  logic                  live1;
  logic                  live2;
  logic                  p1_fifo;
  logic                  p2_fifo;
  logic                  head_hit;
  logic                  p2_hit;
  logic [1:0]            n_free;
  logic [1:0]            pops;
  logic                  we1_d;
  logic                  we2_d;
  logic [REG_ADDR_W-1:0] addr1_d;
  logic [REG_ADDR_W-1:0] addr2_d;
  logic [DATA_W-1:0]     data1_d;
  logic [DATA_W-1:0]     data2_d;

  // Ready comes only from registered count; zero-dest pushes are swallowed.
  assign LL_Ready   = ll_count < CNT_W'(LL_DEPTH);
  assign push       = LL_Valid && LL_Ready && (LL_Dest != '0);
  assign push_entry = '{dest: LL_Dest, data: LL_Data};

  wb_ll_fifo #(
    .DEPTH (LL_DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pops),
    .head       (head),
    .head_nxt   (head_nxt),
`ifdef WB_PENDING_EN
    .pending    (LL_Pending),
`endif
    .count      (ll_count)
  );

  // Slot filtering, free-port fill from the FIFO, and stale-entry discard.
  always_comb begin
    live1 = WB_Valid_1 && (WB_Dest_1 != '0);
    live2 = WB_Valid_2 && (WB_Dest_2 != '0);
    if (live1 && live2 && (WB_Dest_1 == WB_Dest_2)) live1 = 1'b0;

    n_free  = 2'(!live1) + 2'(!live2);
    pops    = (ll_count >= CNT_W'(n_free)) ? n_free : 2'(ll_count);
    p1_fifo = !live1 && (pops != 2'd0);
    p2_fifo = !live2 && (live1 ? (pops != 2'd0) : (pops == 2'd2));
    p2_entry = live1 ? head : head_nxt;

    head_hit = (live1 && head.dest == WB_Dest_1) || (live2 && head.dest == WB_Dest_2);
    p2_hit   = (live1 && p2_entry.dest == WB_Dest_1) || (live2 && p2_entry.dest == WB_Dest_2);

    we1_d   = 1'b0;
    addr1_d = '0;
    data1_d = '0;
    we2_d   = 1'b0;
    addr2_d = '0;
    data2_d = '0;

    if (live1) begin
      we1_d   = 1'b1;
      addr1_d = WB_Dest_1;
      data1_d = WB_Data_1;
    end else if (p1_fifo && !head_hit) begin
      we1_d   = 1'b1;
      addr1_d = head.dest;
      data1_d = head.data;
    end

    if (live2) begin
      we2_d   = 1'b1;
      addr2_d = WB_Dest_2;
      data2_d = WB_Data_2;
    end else if (p2_fifo && !p2_hit) begin
      we2_d   = 1'b1;
      addr2_d = p2_entry.dest;
      data2_d = p2_entry.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Write_Enable_1 <= 1'b0;
      Write_Addr_1   <= '0;
      Write_Data_1   <= '0;
      Write_Enable_2 <= 1'b0;
      Write_Addr_2   <= '0;
      Write_Data_2   <= '0;
    end else begin
      Write_Enable_1 <= we1_d;
      Write_Addr_1   <= addr1_d;
      Write_Data_1   <= data1_d;
      Write_Enable_2 <= we2_d;
      Write_Addr_2   <= addr2_d;
      Write_Data_2   <= data2_d;
    end
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Dual-issue writeback commit stage that drives the two write ports of the register file. It merges the two in-order pipeline results from MEM/WB with results from long-latency units (mul/div) buffered in a small FIFO. It resolves same-destination conflicts and registers the resulting write-port signals. Slot 2 is always the younger instruction.

## Interface
Parameters:
- LL_DEPTH, 4: long-latency result FIFO depth; power of two, minimum 2.

Ports (clock/reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous active-low reset
- WB_Valid_1 / WB_Valid_2  in  1  pipeline slot 1/2 result valid
- WB_Dest_1 / WB_Dest_2  in  5  pipeline slot destination register
- WB_Data_1 / WB_Data_2  in  32  pipeline slot result
- LL_Valid  in  1  long-latency result offered
- LL_Ready  out  1  FIFO accepts; equals (count < LL_DEPTH), from registered count
- LL_Dest  in  5  long-latency destination
- LL_Data  in  32  long-latency result
- Write_Enable_1 / Write_Enable_2  out  1  register-file write enables
- Write_Addr_1 / Write_Addr_2  out  5  register-file write addresses
- Write_Data_1 / Write_Data_2  out  32  register-file write data
- LL_Pending  out  32  one bit per register with a queued FIFO entry (only with WB_PENDING_EN)

## Operation
- Push: an entry is pushed when LL_Valid && LL_Ready. A push with LL_Dest == 0 is accepted and discarded.
- Pipeline filter:
  - A slot is live if it is valid and its destination is non-zero.
  - If both slots are live and WB_Dest_1 == WB_Dest_2, slot 1 is dropped (the younger write wins).
- Port assignment:
  - Live slot 1 goes to port 1; live slot 2 goes to port 2.
  - A port left free takes a FIFO entry in order: the head goes to the first free port (port 1 before port 2), then head+1 goes to the remaining free port.
  - Up to 2 entries can pop per cycle.
- FIFO vs pipeline: a popped entry whose dest equals any live pipeline dest in the same cycle is discarded. It is still popped, but not written, because the pipeline write is younger.
- FIFO vs FIFO: if both popped entries have the same dest, the older goes to port 1 and the younger to port 2. The register file's port-2 precedence then keeps the younger value.
- Push and pop may occur in the same cycle. Count is updated as count + push − pops.
- Pointers are log2(LL_DEPTH) bits and wrap naturally.

## Timing
- Outputs are registered, so a write reaches the register file one cycle after the inputs are sampled (latency 1).
- A FIFO entry pushed in cycle N can pop no earlier than cycle N+1, so it is written at cycle N+2 at the earliest.
- LL_Ready:
  - Depends only on the registered count; there is no combinational path from LL_Valid.
  - A full FIFO deasserts LL_Ready even if a pop occurs in the same cycle.
- Reset (asynchronous assert, synchronous release):
  - All Write_* outputs are 0.
  - FIFO is empty; pointers and count are 0.
  - LL_Ready = 1 at the first clock after release.
  - LL_Pending = 0.
- Reset asserted mid-operation discards all queued entries. No write enable may be asserted during reset.
- No pipeline stall input exists; pipeline slots are never back-pressured.

## Configuration
- WB_PENDING_EN defined:
  - LL_Pending is driven as the OR over valid FIFO entries of a one-hot dest decode.
  - The encoding is register 0 = bit 0, and bit 0 is always 0.
  - The vector is combinational from FIFO state and is used by the issue hazard check.
- WB_PENDING_EN undefined: the LL_Pending port is absent and no mask logic is built.

## Structure
- Shared package holds:
  - REG_ADDR_W = 5, DATA_W = 32
  - the wb_entry_t struct {dest[4:0], data[31:0]}
  - the default LL_DEPTH constant
- One sub-module, wb_ll_fifo: an LL_DEPTH-entry FIFO with 1 push port, 0–2 pop ports, peek of head and head+1, and a count output.
- Arbitration, conflict filtering and output registers live in wb_commit.

## Test plan
- After reset, both slots valid with dest 3/data 0x11 and dest 5/data 0x22 → next cycle WE1=1 addr 3 data 0x11, WE2=1 addr 5 data 0x22.
- Both slots dest 7, data 0xA and 0xB → WE1=0, WE2=1 addr 7 data 0xB.
- Push LL dest 9 data 0x99 while pipeline idle → written on port 1 two cycles after the push; count returns to 0.
- Push LL_DEPTH entries while both slots are busy → LL_Ready=0 once full. Then idle the pipeline → two entries drain per cycle, in order, and LL_Ready reasserts.
- FIFO head dest 4 popped while slot 1 writes dest 4 → only the slot 1 value is written. With WB_PENDING_EN, bit 4 is set while the entry is queued and cleared after the pop.
- Assert reset with 3 entries queued → all write enables 0 immediately. After release, count is 0 and no stale write is ever emitted.
